// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream framing stages: FSM state encoding
// and the header word layout {source id, sequence number}.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_e;

    localparam int HDR_SRC_W = 4;
    localparam int HDR_MAX_W = 64;

    // Built at the widest supported size; callers cast the result down to their data width.
    function automatic logic [HDR_MAX_W-1:0] hdrCompose(
        input logic [HDR_SRC_W-1:0] srcId,
        input logic [HDR_MAX_W-1:0] seq,
        input int                   dataW
    );
        logic [HDR_MAX_W-1:0] seqMask;
        seqMask = {HDR_MAX_W{1'b1}} >> (HDR_MAX_W - dataW + HDR_SRC_W);
        return (HDR_MAX_W'(srcId) << (dataW - HDR_SRC_W)) | (seq & seqMask);
    endfunction

endpackage

// File: rtl/axis_header_inserter_out_reg.sv
// Registered AXI-Stream output slice: one beat of data/last/valid that holds
// steady under backpressure and reports when it can accept a new beat.
module axis_out_reg #(
    parameter int P_DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [P_DATA_WIDTH-1:0] data_i,
    input  logic                    last_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic                    last_o,
    output logic                    free_o
);

    logic                    valid_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic                    last_q;

    // The owner only asserts load_i while free_o is high, so a held beat is never overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a {source id, sequence} header beat to every packet and truncates
// packets longer than P_MAX_BEATS payload beats, discarding the remainder.
module axis_header_inserter
    import axis_pkg::*;
#(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_MAX_BEATS  = 256,
    parameter int P_SRC_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [P_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    trunc_pulse,
    output logic [15:0]             pkt_count,
    output logic [15:0]             trunc_count
);

    localparam int BEAT_W = $clog2(P_MAX_BEATS);
    localparam int SEQ_W  = P_DATA_WIDTH - HDR_SRC_W;

    state_e              state_q, state_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [BEAT_W-1:0]   beatCnt_q, beatCnt_d;
    logic [15:0]         pktCount_q, pktCount_d;
    logic [15:0]         truncCount_q, truncCount_d;
    logic                truncPulse_q, truncPulse_d;

    logic                    outLoad;
    logic [P_DATA_WIDTH-1:0] outData;
    logic                    outLast;
    logic                    outFree;

    // The header is issued without consuming the first input beat; that beat is taken in PAYLOAD.
    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        beatCnt_d     = beatCnt_q;
        pktCount_d    = pktCount_q;
        truncCount_d  = truncCount_q;
        truncPulse_d  = 1'b0;
        outLoad       = 1'b0;
        outData       = s_axis_tdata;
        outLast       = 1'b0;
        s_axis_tready = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && outFree) begin
                    outLoad   = 1'b1;
                    outData   = P_DATA_WIDTH'(hdrCompose(HDR_SRC_W'(P_SRC_ID),
                                                         HDR_MAX_W'(seq_q), P_DATA_WIDTH));
                    beatCnt_d = '0;
                    state_d   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_axis_tready = outFree;
                if (s_axis_tvalid && outFree) begin
                    outLoad   = 1'b1;
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (s_axis_tlast) begin
                        outLast    = 1'b1;
                        seq_d      = seq_q + 1'b1;
                        pktCount_d = pktCount_q + 1'b1;
                        state_d    = IDLE;
                    end else if (beatCnt_q == BEAT_W'(P_MAX_BEATS - 1)) begin
                        outLast      = 1'b1;
                        seq_d        = seq_q + 1'b1;
                        pktCount_d   = pktCount_q + 1'b1;
                        truncCount_d = truncCount_q + 1'b1;
                        truncPulse_d = 1'b1;
                        state_d      = DROP;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            seq_q        <= '0;
            beatCnt_q    <= '0;
            pktCount_q   <= '0;
            truncCount_q <= '0;
            truncPulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            beatCnt_q    <= beatCnt_d;
            pktCount_q   <= pktCount_d;
            truncCount_q <= truncCount_d;
            truncPulse_q <= truncPulse_d;
        end
    end

    axis_out_reg #(
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (outLoad),
        .data_i  (outData),
        .last_i  (outLast),
        .ready_i (m_axis_tready),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .last_o  (m_axis_tlast),
        .free_o  (outFree)
    );

    assign trunc_pulse = truncPulse_q;
    assign pkt_count   = pktCount_q;
    assign trunc_count = truncCount_q;

endmodule

// File: tb/tb_axis_header_inserter.sv
// Directed self-checking bench for axis_header_inserter with source id 5 and
// a 4-beat payload limit, plus a randomised-backpressure scoreboard run.
module tb_axis_header_inserter;

    localparam int DW   = 16;
    localparam int MAXB = 4;
    localparam int SRC  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          trunc_pulse;
    logic [15:0]   pkt_count;
    logic [15:0]   trunc_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] outData[$];
    logic          outLast[$];
    int            outCycle[$];
    logic [DW-1:0] expD[$];
    logic          expL[$];

    int            cycleNo    = 0;
    int            truncHigh  = 0;
    bit            randReady  = 1'b0;
    logic          readyVal   = 1'b1;
    logic          prevStall  = 1'b0;
    logic [DW-1:0] prevData   = '0;
    logic          prevLast   = 1'b0;

    always #5 clk = ~clk;

    axis_header_inserter #(
        .P_DATA_WIDTH(DW),
        .P_MAX_BEATS (MAXB),
        .P_SRC_ID    (SRC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .trunc_pulse  (trunc_pulse),
        .pkt_count    (pkt_count),
        .trunc_count  (trunc_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready is driven at the falling edge; the beat monitor samples once it settles.
    always @(negedge clk) begin
        if (randReady) m_axis_tready = ($urandom_range(0, 1) == 1);
        else           m_axis_tready = readyVal;
        #3;
        cycleNo++;
        if (!rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("holdValid", 32'(m_axis_tvalid), 32'(1));
                checkOutput("holdData", 32'(m_axis_tdata), 32'(prevData));
                checkOutput("holdLast", 32'(m_axis_tlast), 32'(prevLast));
            end
            if (trunc_pulse) truncHigh++;
            if (m_axis_tvalid && m_axis_tready) begin
                outData.push_back(m_axis_tdata);
                outLast.push_back(m_axis_tlast);
                outCycle.push_back(cycleNo);
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevData  = m_axis_tdata;
            prevLast  = m_axis_tlast;
        end
    end

    task automatic clearCapture();
        outData.delete();
        outLast.delete();
        outCycle.delete();
        truncHigh = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clearCapture();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the beat was accepted.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
        int n;
        bit took;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        n    = 0;
        took = 1'b0;
        while (!took && n < 200) begin
            #2;
            took = s_axis_tready;
            @(negedge clk);
            n++;
        end
        checkOutput("sendAccepted", 32'(took), 32'(1));
    endtask

    task automatic endPacket();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input int idx, input logic [DW-1:0] d, input logic l);
        if (idx < outData.size()) begin
            checkOutput({tag, "_data"}, 32'(outData[idx]), 32'(d));
            checkOutput({tag, "_last"}, 32'(outLast[idx]), 32'(l));
        end else begin
            checkOutput({tag, "_present"}, 32'(outData.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        int            len;
        int            w;

        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        readyVal      = 1'b1;

        // Reset values
        #1 rst = 1'b0;
        #1;
        checkOutput("rstTvalid", 32'(m_axis_tvalid), 32'(0));
        checkOutput("rstTdata", 32'(m_axis_tdata), 32'(0));
        checkOutput("rstTlast", 32'(m_axis_tlast), 32'(0));
        checkOutput("rstTrunc", 32'(trunc_pulse), 32'(0));
        checkOutput("rstPktCnt", 32'(pkt_count), 32'(0));
        checkOutput("rstTruncCnt", 32'(trunc_count), 32'(0));
        checkOutput("rstSready", 32'(s_axis_tready), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 3-beat packet
        doReset();
        applyStimulus(16'h0011, 1'b0);
        applyStimulus(16'h0022, 1'b0);
        applyStimulus(16'h0033, 1'b1);
        endPacket();
        waitCycles(4);
        checkOutput("p3Count", 32'(outData.size()), 32'(4));
        checkBeat("p3Hdr", 0, 16'h5000, 1'b0);
        checkBeat("p3B1", 1, 16'h0011, 1'b0);
        checkBeat("p3B2", 2, 16'h0022, 1'b0);
        checkBeat("p3B3", 3, 16'h0033, 1'b1);
        checkOutput("p3PktCnt", 32'(pkt_count), 32'(1));

        // Back-to-back single-beat packets
        doReset();
        applyStimulus(16'hAAAA, 1'b1);
        applyStimulus(16'hBBBB, 1'b1);
        endPacket();
        waitCycles(4);
        checkOutput("b2bCount", 32'(outData.size()), 32'(4));
        checkBeat("b2bHdr0", 0, 16'h5000, 1'b0);
        checkBeat("b2bA", 1, 16'hAAAA, 1'b1);
        checkBeat("b2bHdr1", 2, 16'h5001, 1'b0);
        checkBeat("b2bB", 3, 16'hBBBB, 1'b1);
        if (outCycle.size() == 4)
            checkOutput("b2bSpan", 32'(outCycle[3] - outCycle[0]), 32'(3));
        checkOutput("b2bPktCnt", 32'(pkt_count), 32'(2));

        // 6-beat packet truncated to 4 payload beats, then one more packet
        doReset();
        for (int i = 1; i <= 6; i++) applyStimulus(16'h0100 + 16'(i), (i == 6));
        endPacket();
        waitCycles(4);
        checkOutput("trCount", 32'(outData.size()), 32'(5));
        checkBeat("trHdr", 0, 16'h5000, 1'b0);
        checkBeat("trB1", 1, 16'h0101, 1'b0);
        checkBeat("trB3", 3, 16'h0103, 1'b0);
        checkBeat("trB4", 4, 16'h0104, 1'b1);
        checkOutput("trPulseCycles", 32'(truncHigh), 32'(1));
        checkOutput("trTruncCnt", 32'(trunc_count), 32'(1));
        checkOutput("trPktCnt", 32'(pkt_count), 32'(1));
        applyStimulus(16'h0CCC, 1'b1);
        endPacket();
        waitCycles(4);
        checkOutput("trNextCount", 32'(outData.size()), 32'(7));
        checkBeat("trNextHdr", 5, 16'h5001, 1'b0);
        checkBeat("trNextB", 6, 16'h0CCC, 1'b1);

        // Exactly P_MAX_BEATS payload beats ends normally
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(16'h0200 + 16'(i), (i == 4));
        endPacket();
        waitCycles(3);
        #2;
        checkOutput("exIdleSready", 32'(s_axis_tready), 32'(0));
        waitCycles(1);
        checkOutput("exCount", 32'(outData.size()), 32'(5));
        checkBeat("exB4", 4, 16'h0204, 1'b1);
        checkOutput("exTruncCnt", 32'(trunc_count), 32'(0));
        checkOutput("exPulseCycles", 32'(truncHigh), 32'(0));
        checkOutput("exPktCnt", 32'(pkt_count), 32'(1));
        applyStimulus(16'h0DDD, 1'b1);
        endPacket();
        waitCycles(4);
        checkBeat("exNextHdr", 5, 16'h5001, 1'b0);
        checkBeat("exNextB", 6, 16'h0DDD, 1'b1);

        // 100 packets under random downstream backpressure
        doReset();
        expD.delete();
        expL.delete();
        randReady = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = int'($urandom_range(1, MAXB));
            expD.push_back({4'(SRC), p[11:0]});
            expL.push_back(1'b0);
            for (int b = 0; b < len; b++) begin
                d = 16'($urandom);
                expD.push_back(d);
                expL.push_back(b == len - 1);
                applyStimulus(d, (b == len - 1));
            end
        end
        endPacket();
        w = 0;
        while (outData.size() < expD.size() && w < 3000) begin
            @(negedge clk);
            w++;
        end
        randReady = 1'b0;
        waitCycles(2);
        checkOutput("rndCount", 32'(outData.size()), 32'(expD.size()));
        for (int i = 0; i < expD.size(); i++)
            checkBeat($sformatf("rnd%0d", i), i, expD[i], expL[i]);
        checkOutput("rndPktCnt", 32'(pkt_count), 32'(100));
        checkOutput("rndTruncCnt", 32'(trunc_count), 32'(0));

        // Reset asserted during the second beat of a packet
        doReset();
        applyStimulus(16'h0E01, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h0E02;
        s_axis_tlast  = 1'b0;
        #1 rst = 1'b0;
        #1;
        checkOutput("midRstTvalid", 32'(m_axis_tvalid), 32'(0));
        checkOutput("midRstTdata", 32'(m_axis_tdata), 32'(0));
        checkOutput("midRstTlast", 32'(m_axis_tlast), 32'(0));
        checkOutput("midRstSready", 32'(s_axis_tready), 32'(0));
        checkOutput("midRstPktCnt", 32'(pkt_count), 32'(0));
        endPacket();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clearCapture();
        applyStimulus(16'h0EEE, 1'b1);
        endPacket();
        waitCycles(4);
        checkOutput("postRstCount", 32'(outData.size()), 32'(2));
        checkBeat("postRstHdr", 0, 16'h5000, 1'b0);
        checkBeat("postRstB", 1, 16'h0EEE, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_header_inserter.md
Name: axis_header_inserter

Overview:
- AXI-Stream framing stage that sits directly downstream of sync_fifo and consumes its m_axis output.
- Prepends one header beat to every packet. The header carries a fixed source ID and a rolling sequence number.
- Truncates packets longer than P_MAX_BEATS payload beats: forces tlast, then discards the remainder of the source packet.
- Output is fully registered so it can drive long routes to the next block.

Parameters:
- P_DATA_WIDTH, 16, data width of both streams; must be at least 8.
- P_MAX_BEATS, 256, maximum payload beats per output packet, excluding the header; must be at least 2.
- P_SRC_ID, 0, 4-bit source identifier placed in the header MSBs.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets; deassert synchronously to clk).
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tready  output  1  upstream beat accept.
- s_axis_tdata  input  P_DATA_WIDTH  upstream payload.
- s_axis_tlast  input  1  last beat of upstream packet.
- m_axis_tvalid  output  1  downstream beat valid (registered).
- m_axis_tready  input  1  downstream accept.
- m_axis_tdata  output  P_DATA_WIDTH  header or payload (registered).
- m_axis_tlast  output  1  last beat of output packet (registered).
- trunc_pulse  output  1  one-cycle pulse when a packet is truncated.
- pkt_count  output  16  packets emitted; wraps.
- trunc_count  output  16  packets truncated; wraps.

Behaviour:
- Reset values: all outputs 0; state=IDLE; seq=0; beat_cnt=0. s_axis_tready=0.
- Output register "free" = !m_axis_tvalid || m_axis_tready.
- Output data, tlast and tvalid are held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI rule). tvalid never drops without a handshake.
- FSM states: IDLE, PAYLOAD, DROP.
- IDLE:
  - s_axis_tready=0.
  - When s_axis_tvalid=1 and the output register is free: load header {P_SRC_ID[3:0], seq[P_DATA_WIDTH-5:0]}, tlast=0, tvalid=1; clear beat_cnt; go to PAYLOAD.
  - The input beat is not consumed.
  - Header appears on m_axis one cycle after the qualifying edge.
- PAYLOAD:
  - s_axis_tready = output register free (combinational).
  - On input handshake: register s_axis_tdata to the output with tvalid=1; beat_cnt++.
  - If s_axis_tlast=1: m_axis_tlast=1; seq++ (wraps at 2^(P_DATA_WIDTH-4)); pkt_count++; go to IDLE.
  - Else if beat_cnt==P_MAX_BEATS-1: m_axis_tlast=1 (forced); seq++; pkt_count++; trunc_count++; trunc_pulse=1 for one cycle; go to DROP.
  - If tlast arrives exactly on beat P_MAX_BEATS, it is a normal end: no truncation, no DROP.
- DROP:
  - s_axis_tready=1 regardless of the output register.
  - Beats are discarded and m_axis is untouched; pending output beats drain normally.
  - On a handshake with s_axis_tlast=1, go to IDLE.
- If no output register is free when a header is due, the header waits in IDLE. A held header is never overwritten.
- Back-to-back packets: each packet costs one header beat, so there is no other bubble. Peak throughput is N/(N+1) for N-beat packets.
- Widths: beat_cnt is $clog2(P_MAX_BEATS) bits; counters wrap silently.
- Reset mid-packet: FSM returns to IDLE and any in-flight output beat is lost. Upstream shares rst, so the next input beat starts a new packet.

Decomposition:
- Shared package axis_pkg holds:
  - the FSM state enum (IDLE/PAYLOAD/DROP);
  - header field constants: HDR_SRC_W=4, and the header-compose function (src_id, seq) -> header word.
- One natural sub-module: axis_out_reg. It is the registered AXI output slice (data, last, valid, with hold under backpressure) and is reusable by later stages.
- FSM and counters stay in the top.

Test Plan:
- 3-beat packet 0x0011,0x0022,0x0033(last), P_SRC_ID=5, m_tready=1 -> m_axis: 0x5000, 0x0011, 0x0022, 0x0033(last); pkt_count=1.
- Two back-to-back 1-beat packets 0xAAAA(last), 0xBBBB(last) -> 0x5000, 0xAAAA(last), 0x5001, 0xBBBB(last); no bubbles other than the headers.
- P_MAX_BEATS=4, 6-beat input packet -> header plus 4 payload beats, the 4th with tlast=1. trunc_pulse high exactly one cycle; beats 5-6 consumed with no m_axis output; trunc_count=1. The next packet's header seq=1.
- Exactly 4-beat packet with P_MAX_BEATS=4 -> normal end; trunc_count stays 0; state returns to IDLE, not DROP.
- Randomised m_axis_tready (50%) over 100 packets -> output data/last stable whenever valid && !ready; payload sequence matches a scoreboard; seq increments 0..99.
- Assert rst=0 during the 2nd beat of a packet -> all outputs 0 asynchronously. After release, the next s_axis beat gets header seq=0.
